// File: rtl/note_sequencer.sv
// Note sequencer: plays a table of (pitch, duration) entries from a small
// note memory, advancing one entry per programmed number of sample ticks.
module note_sequencer #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_pitch,
  input  logic [DW-1:0] wr_dur,
  input  logic [AW-1:0] len,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  output logic [3:0]    pitch,
  output logic          note_valid,
  output logic          note_start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] cur_idx
);

  localparam logic [3:0] REST = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t        state_q;
  logic [3+DW:0] mem [DEPTH];
  logic [3+DW:0] rd_word;
  logic [3:0]    ent_pitch_q;
  logic [DW-1:0] ent_dur_q;
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] last_cnt_d;
  logic          entry_end_d;
  logic [AW-1:0] len_q;
  logic [AW-1:0] cur_idx_q;
  logic [AW-1:0] idx_next_d;
  logic [3:0]    pitch_q;
  logic          note_valid_q;
  logic          note_start_q;
  logic          busy_q;
  logic          done_q;

  // Note memory: written at any time, never reset; LOAD reads the old word
  // when it collides with a write in the same cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {wr_pitch, wr_dur};
  end

  assign rd_word = mem[cur_idx_q];

  // Entry-end detection: a zero duration is treated as one tick.
  always_comb begin
    last_cnt_d  = (ent_dur_q == '0) ? '0 : ent_dur_q - DW'(1);
    entry_end_d = tick && (cnt_q == last_cnt_d);
    idx_next_d  = cur_idx_q + AW'(1);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ent_pitch_q  <= REST;
      ent_dur_q    <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      cur_idx_q    <= '0;
      pitch_q      <= REST;
      note_valid_q <= 1'b0;
      note_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      note_start_q <= 1'b0;
      done_q       <= 1'b0;
      if (stop) begin
        state_q      <= IDLE;
        pitch_q      <= REST;
        note_valid_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            pitch_q      <= REST;
            note_valid_q <= 1'b0;
            if (start) begin
              state_q   <= LOAD;
              cur_idx_q <= '0;
              len_q     <= len;
              busy_q    <= 1'b1;
            end
          end
          LOAD: begin
            // Outputs are set here so they appear on the first PLAY cycle.
            ent_pitch_q  <= rd_word[3+DW:DW];
            ent_dur_q    <= rd_word[DW-1:0];
            cnt_q        <= '0;
            pitch_q      <= rd_word[3+DW:DW];
            note_valid_q <= (rd_word[3+DW:DW] != REST);
            note_start_q <= 1'b1;
            state_q      <= PLAY;
          end
          PLAY: begin
            if (entry_end_d) begin
              if (cur_idx_q != len_q) begin
                cur_idx_q <= idx_next_d;
                state_q   <= LOAD;
              end else if (loop_en) begin
                cur_idx_q <= '0;
                state_q   <= LOAD;
              end else begin
                state_q      <= IDLE;
                done_q       <= 1'b1;
                busy_q       <= 1'b0;
                pitch_q      <= REST;
                note_valid_q <= 1'b0;
              end
            end else if (tick) begin
              cnt_q <= cnt_q + DW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pitch      = pitch_q;
  assign note_valid = note_valid_q;
  assign note_start = note_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cur_idx    = cur_idx_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a negedge monitor logs every entry start
// and done pulse; each test task compares that log against hand-worked values.
module tb_note_sequencer;

  localparam int AW = 5;
  localparam int DW = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [3:0]    wr_pitch = '0;
  logic [DW-1:0] wr_dur = '0;
  logic [AW-1:0] len = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [3:0]    pitch;
  logic          note_valid;
  logic          note_start;
  logic          busy;
  logic          done;
  logic [AW-1:0] cur_idx;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor log
  int            n_ns;
  int            n_done;
  int            tcnt;
  int            done_t;
  logic [3:0]    lp [8];
  logic          lv [8];
  logic [AW-1:0] li [8];
  int            lt [8];

  note_sequencer #(.DEPTH(32), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .tick(tick), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_pitch(wr_pitch), .wr_dur(wr_dur), .len(len), .start(start),
    .stop(stop), .loop_en(loop_en), .pitch(pitch), .note_valid(note_valid),
    .note_start(note_start), .busy(busy), .done(done), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (note_start && n_ns < 8) begin
      lp[n_ns] = pitch;
      lv[n_ns] = note_valid;
      li[n_ns] = cur_idx;
      lt[n_ns] = tcnt;
      n_ns = n_ns + 1;
    end
    if (done) begin
      n_done = n_done + 1;
      done_t = tcnt;
    end
    if (tick) tcnt = tcnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One tick strobe followed by nine quiet cycles.
  task automatic tk();
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (9) step();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [3:0] p, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_pitch = p; wr_dur = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic clr_log();
    n_ns = 0; n_done = 0; tcnt = 0; done_t = -1;
  endtask

  // Start and advance to the first PLAY cycle so no tick lands in LOAD.
  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    clr_log();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    n_cmp++; if (pitch !== 4'hF) begin n_bad++; $display("FAIL reset_pitch: got %h want f", pitch); end
    n_cmp++; if ({note_valid, note_start, busy, done} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {note_valid, note_start, busy, done}); end
    n_cmp++; if (cur_idx !== 5'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", cur_idx); end
  endtask

  task automatic test_basic();
    logic [3:0] ep [2];
    int         et [2];
    ep[0] = 4'h7; ep[1] = 4'h4; et[0] = 0; et[1] = 3;
    wr(5'd0, 4'h7, 13'd3);
    wr(5'd1, 4'h4, 13'd2);
    len = 5'd1; loop_en = 1'b0;
    clr_log();
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_load: got %b want 1", busy); end
    step();
    n_cmp++; if ({note_start, note_valid, pitch} !== 6'b11_0111) begin n_bad++; $display("FAIL basic_first_play: got %b want 110111", {note_start, note_valid, pitch}); end
    repeat (5) tk();
    n_cmp++; if (n_ns !== 2) begin n_bad++; $display("FAIL basic_entries: got %0d want 2", n_ns); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (lp[k] !== ep[k] || lt[k] != et[k] || lv[k] !== 1'b1) begin n_bad++; $display("FAIL basic_entry%0d: got p=%h t=%0d v=%b want p=%h t=%0d v=1", k, lp[k], lt[k], lv[k], ep[k], et[k]); end
    end
    n_cmp++; if (n_done != 1 || done_t != 5) begin n_bad++; $display("FAIL basic_done: got cnt=%0d t=%0d want cnt=1 t=5", n_done, done_t); end
    n_cmp++; if ({busy, note_valid, pitch} !== 6'b00_1111) begin n_bad++; $display("FAIL basic_idle: got %b want 001111", {busy, note_valid, pitch}); end
  endtask

  task automatic test_rest();
    logic [3:0] ep [3];
    logic       ev [3];
    int         et [3];
    ep[0] = 4'h7; ep[1] = 4'hF; ep[2] = 4'h4;
    ev[0] = 1'b1; ev[1] = 1'b0; ev[2] = 1'b1;
    et[0] = 0;    et[1] = 1;    et[2] = 3;
    wr(5'd0, 4'h7, 13'd1);
    wr(5'd1, 4'hF, 13'd2);
    wr(5'd2, 4'h4, 13'd1);
    len = 5'd2; loop_en = 1'b0;
    clr_log();
    go();
    repeat (4) tk();
    n_cmp++; if (n_ns !== 3) begin n_bad++; $display("FAIL rest_entries: got %0d want 3", n_ns); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (lp[k] !== ep[k] || lv[k] !== ev[k] || lt[k] != et[k]) begin n_bad++; $display("FAIL rest_entry%0d: got p=%h v=%b t=%0d want p=%h v=%b t=%0d", k, lp[k], lv[k], lt[k], ep[k], ev[k], et[k]); end
    end
    n_cmp++; if (n_done != 1 || done_t != 4) begin n_bad++; $display("FAIL rest_done: got cnt=%0d t=%0d want cnt=1 t=4", n_done, done_t); end
  endtask

  task automatic test_loop();
    logic [AW-1:0] ei [4];
    ei[0] = 5'd0; ei[1] = 5'd1; ei[2] = 5'd0; ei[3] = 5'd1;
    wr(5'd0, 4'h3, 13'd1);
    wr(5'd1, 4'h5, 13'd1);
    len = 5'd1; loop_en = 1'b1;
    clr_log();
    go();
    repeat (3) tk();
    n_cmp++; if (n_ns !== 4) begin n_bad++; $display("FAIL loop_entries: got %0d want 4", n_ns); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (li[k] !== ei[k] || lt[k] != k) begin n_bad++; $display("FAIL loop_entry%0d: got idx=%0d t=%0d want idx=%0d t=%0d", k, li[k], lt[k], ei[k], k); end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_cmp++; if ({busy, note_valid, pitch} !== 6'b00_1111) begin n_bad++; $display("FAIL loop_stop: got %b want 001111", {busy, note_valid, pitch}); end
    n_cmp++; if (cur_idx !== 5'd1) begin n_bad++; $display("FAIL loop_stop_idx: got %0d want 1", cur_idx); end
    repeat (3) step();
    n_cmp++; if (n_done != 0) begin n_bad++; $display("FAIL loop_no_done: got %0d want 0", n_done); end
    loop_en = 1'b0;
  endtask

  task automatic test_dur0();
    wr(5'd0, 4'h2, 13'd0);
    wr(5'd1, 4'h6, 13'd1);
    len = 5'd1; loop_en = 1'b0;
    clr_log();
    go();
    repeat (2) tk();
    n_cmp++; if (n_ns != 2 || lt[1] != 1 || lp[1] !== 4'h6) begin n_bad++; $display("FAIL dur0_second: got n=%0d t=%0d p=%h want n=2 t=1 p=6", n_ns, lt[1], lp[1]); end
    n_cmp++; if (n_done != 1 || done_t != 2) begin n_bad++; $display("FAIL dur0_done: got cnt=%0d t=%0d want cnt=1 t=2", n_done, done_t); end
    clr_log();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL startstop_busy: got %b want 0", busy); end
    repeat (3) step();
    n_cmp++; if (busy !== 1'b0 || n_ns != 0) begin n_bad++; $display("FAIL startstop_idle: got busy=%b n=%0d want busy=0 n=0", busy, n_ns); end
  endtask

  task automatic test_reset_mid();
    wr(5'd0, 4'h9, 13'd2);
    wr(5'd1, 4'hA, 13'd3);
    len = 5'd1; loop_en = 1'b0;
    clr_log();
    go();
    repeat (3) tk();
    n_cmp++; if (cur_idx !== 5'd1 || busy !== 1'b1 || pitch !== 4'hA) begin n_bad++; $display("FAIL midnote_pre: got idx=%0d busy=%b p=%h want idx=1 busy=1 p=a", cur_idx, busy, pitch); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({pitch, note_valid, note_start, busy, done, cur_idx} !== {4'hF, 4'b0000, 5'd0}) begin n_bad++; $display("FAIL midnote_async_reset: got p=%h v=%b s=%b b=%b d=%b i=%0d want p=f all 0", pitch, note_valid, note_start, busy, done, cur_idx); end
    step();
    reset = 1'b0;
    step();
    clr_log();
    go();
    repeat (5) tk();
    n_cmp++; if (n_ns != 2 || lp[0] !== 4'h9 || lp[1] !== 4'hA || lt[1] != 2) begin n_bad++; $display("FAIL midnote_replay: got n=%0d p0=%h p1=%h t1=%0d want n=2 p0=9 p1=a t1=2", n_ns, lp[0], lp[1], lt[1]); end
    n_cmp++; if (n_done != 1 || done_t != 5) begin n_bad++; $display("FAIL midnote_done: got cnt=%0d t=%0d want cnt=1 t=5", n_done, done_t); end
  endtask

  task automatic test_wr_during_load();
    logic [3:0] ep [4];
    ep[0] = 4'h1; ep[1] = 4'h2; ep[2] = 4'h1; ep[3] = 4'hC;
    wr(5'd0, 4'h1, 13'd1);
    wr(5'd1, 4'h2, 13'd1);
    len = 5'd1; loop_en = 1'b1;
    clr_log();
    go();
    tick = 1'b1;
    step();
    tick = 1'b0;
    wr(5'd1, 4'hC, 13'd1);
    n_cmp++; if (note_start !== 1'b1 || pitch !== 4'h2) begin n_bad++; $display("FAIL wrload_old: got s=%b p=%h want s=1 p=2", note_start, pitch); end
    repeat (9) step();
    repeat (2) tk();
    n_cmp++; if (n_ns !== 4) begin n_bad++; $display("FAIL wrload_entries: got %0d want 4", n_ns); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (lp[k] !== ep[k]) begin n_bad++; $display("FAIL wrload_entry%0d: got p=%h want p=%h", k, lp[k], ep[k]); end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop_en = 1'b0;
    n_cmp++; if (busy !== 1'b0 || n_done != 0) begin n_bad++; $display("FAIL wrload_stop: got busy=%b done=%0d want busy=0 done=0", busy, n_done); end
  endtask

  initial begin
    clr_log();
    test_reset();
    test_basic();
    test_rest();
    test_loop();
    test_dur0();
    test_reset_mid();
    test_wr_during_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter DEPTH, 32: number of note entries in the note memory.
REQ-002 Parameter AW, 5: address width; DEPTH SHALL equal 2**AW.
REQ-003 Parameter DW, 13: duration field width, in fs ticks.
REQ-004 clk  in  1  single system clock; all state on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 tick  in  1  one-clk-wide sample-rate strobe (fs = 8 kHz), counted as duration units.
REQ-007 wr_en  in  1  write strobe for the note memory.
REQ-008 wr_addr  in  AW  write address.
REQ-009 wr_pitch  in  4  pitch code; 4'hF = rest.
REQ-010 wr_dur  in  DW  note duration in ticks.
REQ-011 len  in  AW  index of the last note; sampled on accepted start.
REQ-012 start  in  1  begin playback at index 0.
REQ-013 stop  in  1  abort playback.
REQ-014 loop_en  in  1  wrap to index 0 after the last note instead of finishing.
REQ-015 pitch  out  4  current pitch code to the tone generator.
REQ-016 note_valid  out  1  high while a non-rest note plays.
REQ-017 note_start  out  1  one-cycle pulse at the first PLAY cycle of every entry, rests included.
REQ-018 busy  out  1  high in LOAD or PLAY.
REQ-019 done  out  1  one-cycle pulse on natural end of a non-looping sequence.
REQ-020 cur_idx  out  AW  index of the entry being loaded or played.

Function
REQ-021 Memory: DEPTH x (4+DW) bits; synchronous write on wr_en at any time, in any state; read-before-write when the LOAD address equals wr_addr in the same cycle.
REQ-022 FSM states: IDLE, LOAD, PLAY.
REQ-023 IDLE: start (without stop) -> LOAD next cycle; cur_idx<=0; len_q<=len.
REQ-024 LOAD lasts exactly one cycle: latch pitch_q/dur_q from mem[cur_idx]; clear duration counter; tick ignored; -> PLAY.
REQ-025 First PLAY cycle: note_start=1; pitch=pitch_q; note_valid=(pitch_q!=4'hF).
REQ-026 PLAY: counter increments only on tick; the entry ends on the tick where counter==max(dur_q,1)-1, so dur 0 plays as 1 tick.
REQ-027 Entry end with cur_idx!=len_q: cur_idx<=cur_idx+1; -> LOAD.
REQ-028 Entry end with cur_idx==len_q and loop_en=1: cur_idx<=0; -> LOAD; no done.
REQ-029 Entry end with cur_idx==len_q and loop_en=0: -> IDLE; done=1 for one cycle.
REQ-030 loop_en is sampled only at the last entry's end.
REQ-031 stop in any state -> IDLE next cycle: pitch<=4'hF, note_valid<=0; no done; cur_idx holds.
REQ-032 stop wins over start in the same cycle; start while busy is ignored.
REQ-033 Outputs are registered; pitch holds between entries; pitch=4'hF and note_valid=0 in IDLE.
REQ-034 Duration counter is DW bits and never wraps; max duration is 2**DW-1 ticks.
REQ-035 A write to the currently playing entry has no effect until that entry is next loaded.

Reset
REQ-036 Asserting reset forces IDLE, pitch=4'hF, note_valid=0, note_start=0, busy=0, done=0, cur_idx=0, counter=0, len_q=0, mid-note included.
REQ-037 Memory contents are not reset; they are retained across reset.

Verification
REQ-038 Write {0:(7,3),1:(4,2)}, len=1, loop_en=0, start, ticks every 10 clk -> pitch 7 for 3 ticks, then 4 for 2 ticks, done pulse, busy=0, pitch=F.
REQ-039 Entry (F,2) between notes -> note_valid=0, note_start pulses, pitch=F for 2 ticks.
REQ-040 loop_en=1, len=1 -> after index 1, cur_idx=0, note_start pulses, no done; stop -> IDLE next cycle, no done.
REQ-041 Entry dur=0 -> plays exactly 1 tick; start+stop same cycle from IDLE -> busy stays 0.
REQ-042 Reset mid-note (cur_idx=1) -> all outputs at reset values; restart replays from index 0 with old memory.
REQ-043 Write mem[1] during the LOAD of index 1 -> old value plays; new value plays on the next loop.
